// File: rtl/smi_write_receiver.sv
// -----------------------------------------------------------------------------
// smi_write_receiver
//   Pi->FPGA half of the SMI link. Captures 16-bit words written by the Pi
//   (SWE strobe, active low) to a single SMI address into a small FIFO in the
//   clk (48 MHz HFOSC) domain. The words are presented to fabric logic as a
//   valid/ready stream with first-word-fall-through.
//
//   Optional feature macro: SMI_RX_SEQ_CHECK_EN
//     When defined, each pushed word is compared against (previous pushed
//     word + 1) mod 2**16. Each mismatch increments o_err_count, which
//     saturates at 16'hFFFF. When undefined, o_err_count is tied to zero.
//
// Ports
//   clk          in   1   fabric clock, sole clock
//   rst          in   1   synchronous reset, active high
//   smi_sa       in   6   SMI address {SA5..SA0}, async to clk
//   smi_swe      in   1   SMI write strobe, active low, async to clk
//   smi_sd       in   16  SMI data {SD15..SD0}, async to clk
//   o_data       out  16  head-of-FIFO word
//   o_valid      out  1   o_data valid
//   i_ready      in   1   consumer accepts o_data when o_valid & i_ready
//   o_overflow   out  1   sticky: a matching write was dropped (FIFO full)
//   o_err_count  out  16  sequence-error count (zero unless checker built)
// -----------------------------------------------------------------------------
module smi_write_receiver #(
   parameter logic [5:0]  ADDR       = 6'b010101,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  smi_sa,
   input  logic        smi_swe,
   input  logic [15:0] smi_sd,
   output logic [15:0] o_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_overflow,
   output logic [15:0] o_err_count
);

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 6;
   localparam int unsigned PW    = DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   // ---------------------------------------------------------------------
   // Input synchronisers (2-FF). Reset to 0 so that a strobe that is still
   // low when reset releases produces no falling edge and stays unarmed.
   // ---------------------------------------------------------------------
   logic          r_swe_m;
   logic          r_swe_s;
   logic [AW-1:0] r_sa_m;
   logic [AW-1:0] r_sa_s;
   logic [DW-1:0] r_sd_m;
   logic [DW-1:0] r_sd_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_swe_m <= 1'b0;
         r_swe_s <= 1'b0;
         r_sa_m  <= '0;
         r_sa_s  <= '0;
         r_sd_m  <= '0;
         r_sd_s  <= '0;
      end else begin
         r_swe_m <= smi_swe;
         r_swe_s <= r_swe_m;
         r_sa_m  <= smi_sa;
         r_sa_s  <= r_sa_m;
         r_sd_m  <= smi_sd;
         r_sd_s  <= r_sd_m;
      end
   end

   // ---------------------------------------------------------------------
   // Strobe edge detection, arming and capture of address/data
   // ---------------------------------------------------------------------
   logic          r_swe_prev;
   logic          r_armed;
   logic [AW-1:0] r_cap_sa;
   logic [DW-1:0] r_cap_sd;
   logic          w_swe_fall;
   logic          w_swe_rise;
   logic          w_wr_evt;

   assign w_swe_fall = r_swe_prev & ~r_swe_s;
   assign w_swe_rise = ~r_swe_prev & r_swe_s;
   // Capture regs still hold the last low-phase sample on the rise cycle.
   assign w_wr_evt   = w_swe_rise & r_armed & (r_cap_sa == ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_swe_prev <= 1'b0;
         r_armed    <= 1'b0;
         r_cap_sa   <= '0;
         r_cap_sd   <= '0;
      end else begin
         r_swe_prev <= r_swe_s;
         if (w_swe_fall) begin
            r_armed <= 1'b1;
         end
         if (!r_swe_s) begin
            r_cap_sa <= r_sa_s;
            r_cap_sd <= r_sd_s;
         end
      end
   end

   // ---------------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------------
   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic          r_overflow;

   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [PW-1:0] w_rd_ptr_nxt;
   logic [CW-1:0] w_count_nxt;
   logic [DW-1:0] w_head_nxt;

   assign w_full       = (r_count == CW'(DEPTH));
   assign w_pop        = r_valid & i_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign w_push       = w_wr_evt & (~w_full | w_pop);
   assign w_drop       = w_wr_evt & w_full & ~w_pop;
   assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
   assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
   // Next head bypasses memory when it is the word being written now.
   assign w_head_nxt   = (w_push && (w_rd_ptr_nxt == r_wr_ptr)) ? r_cap_sd
                                                                : r_mem[w_rd_ptr_nxt];

   // Storage array: no reset needed, pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_cap_sd;
      end
   end

   // Pointers, count and registered head/valid outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         r_valid  <= (w_count_nxt != '0);
         if (w_count_nxt != '0) begin
            r_data <= w_head_nxt;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_data     = r_data;
   assign o_valid    = r_valid;
   assign o_overflow = r_overflow;

   // ---------------------------------------------------------------------
   // Optional sequence checker on pushed words
   // ---------------------------------------------------------------------
`ifdef SMI_RX_SEQ_CHECK_EN
   logic          r_have_ref;
   logic [DW-1:0] r_ref;
   logic [DW-1:0] r_err_cnt;
   logic [DW-1:0] w_seq_exp;

   assign w_seq_exp = r_ref + DW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_have_ref <= 1'b0;
         r_ref      <= '0;
         r_err_cnt  <= '0;
      end else if (w_push) begin
         r_have_ref <= 1'b1;
         r_ref      <= r_cap_sd;
         if (r_have_ref && (r_cap_sd != w_seq_exp) && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + DW'(1);
         end
      end
   end

   assign o_err_count = r_err_cnt;
`else
   assign o_err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_smi_write_receiver.sv
// -----------------------------------------------------------------------------
// tb_smi_write_receiver
//   Directed self-checking bench for smi_write_receiver. Drives SMI write
//   strobes on the pins and checks the output stream, overflow flag and
//   sequence-error counter against hand-computed values.
// -----------------------------------------------------------------------------
module tb_smi_write_receiver;

   localparam logic [5:0] ADDR  = 6'b010101;
   localparam logic [5:0] OTHER = 6'b101010;
`ifdef SMI_RX_SEQ_CHECK_EN
   localparam logic [15:0] EXP_ERR = 16'd1;
`else
   localparam logic [15:0] EXP_ERR = 16'd0;
`endif

   logic        clk;
   logic        rst;
   logic [5:0]  smi_sa;
   logic        smi_swe;
   logic [15:0] smi_sd;
   logic [15:0] o_data;
   logic        o_valid;
   logic        i_ready;
   logic        o_overflow;
   logic [15:0] o_err_count;

   int n_tests = 0;
   int n_fail  = 0;

   smi_write_receiver #(
      .ADDR       (ADDR),
      .DEPTH_LOG2 (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .smi_sa      (smi_sa),
      .smi_swe     (smi_swe),
      .smi_sd      (smi_sd),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_overflow  (o_overflow),
      .o_err_count (o_err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // SWE low 4 clk, then high; returns #1 after the push edge (edge 3).
   // With pop_at_push, i_ready is high only for the push edge.
   task automatic strobe(input logic [5:0] sa, input logic [15:0] sd, input bit pop_at_push);
      @(negedge clk);
      smi_sa  = sa;
      smi_sd  = sd;
      smi_swe = 1'b0;
      repeat (4) @(negedge clk);
      smi_swe = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      if (pop_at_push) i_ready = 1'b1;
      @(posedge clk);
      #1;
      if (pop_at_push) i_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] exp_w;
      rst     = 1'b1;
      smi_sa  = 6'd0;
      smi_swe = 1'b1;
      smi_sd  = 16'd0;
      i_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_valid", 16'(o_valid), 16'd0);
      chk("rst_data", o_data, 16'h0000);
      chk("rst_ovf", 16'(o_overflow), 16'd0);
      chk("rst_err", o_err_count, 16'h0000);

      // 1: single write, consumer ready -> one-cycle valid pulse
      i_ready = 1'b1;
      strobe(ADDR, 16'h1234, 1'b0);
      chk("t1_valid", 16'(o_valid), 16'd1);
      chk("t1_data", o_data, 16'h1234);
      @(posedge clk);
      #1;
      chk("t1_valid_drop", 16'(o_valid), 16'd0);
      chk("t1_data_hold", o_data, 16'h1234);

      // 2: write to another address is ignored
      strobe(OTHER, 16'hBEEF, 1'b0);
      repeat (3) @(negedge clk);
      chk("t2_valid", 16'(o_valid), 16'd0);
      chk("t2_ovf", 16'(o_overflow), 16'd0);
      chk("t2_data", o_data, 16'h1234);

      // 3: fill past capacity with consumer stalled, then drain
      i_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         strobe(ADDR, 16'(i), 1'b0);
         if (i == 15) begin
            chk("t3_ovf_at_full", 16'(o_overflow), 16'd0);
            chk("t3_head_at_full", o_data, 16'h0000);
         end
      end
      chk("t3_ovf", 16'(o_overflow), 16'd1);
      chk("t3_valid", 16'(o_valid), 16'd1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("t3_drain_valid", 16'(o_valid), 16'd1);
         chk("t3_drain_data", o_data, 16'(i));
         i_ready = 1'b1;
      end
      @(negedge clk);
      chk("t3_empty", 16'(o_valid), 16'd0);
      chk("t3_ovf_sticky", 16'(o_overflow), 16'd1);
      i_ready = 1'b0;

      // 4: full FIFO, write coincides with pop -> both succeed
      do_reset();
      @(negedge clk);
      chk("t4_ovf_rst", 16'(o_overflow), 16'd0);
      for (int i = 0; i < 16; i++) begin
         strobe(ADDR, 16'h0100 + 16'(i), 1'b0);
      end
      chk("t4_full_head", o_data, 16'h0100);
      strobe(ADDR, 16'hAAAA, 1'b1);
      chk("t4_ovf", 16'(o_overflow), 16'd0);
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         exp_w = (i < 15) ? (16'h0101 + 16'(i)) : 16'hAAAA;
         chk("t4_drain_valid", 16'(o_valid), 16'd1);
         chk("t4_drain_data", o_data, exp_w);
         i_ready = 1'b1;
         @(negedge clk);
      end
      chk("t4_empty", 16'(o_valid), 16'd0);
      chk("t4_ovf_end", 16'(o_overflow), 16'd0);
      i_ready = 1'b0;

      // 5: reset during a low strobe; the trailing rise must not push
      @(negedge clk);
      smi_sa  = ADDR;
      smi_sd  = 16'h5555;
      smi_swe = 1'b0;
      rst     = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      smi_swe = 1'b1;
      repeat (6) @(negedge clk);
      chk("t5_no_push", 16'(o_valid), 16'd0);
      chk("t5_data_rst", o_data, 16'h0000);
      strobe(ADDR, 16'h7777, 1'b0);
      chk("t5_next_valid", 16'(o_valid), 16'd1);
      chk("t5_next_data", o_data, 16'h7777);

      // 6: sequence checker: 5,6,7,9,10 has one gap
      do_reset();
      @(negedge clk);
      chk("t6_err_rst", o_err_count, 16'h0000);
      i_ready = 1'b1;
      strobe(ADDR, 16'd5, 1'b0);
      strobe(ADDR, 16'd6, 1'b0);
      strobe(ADDR, 16'd7, 1'b0);
      chk("t6_err_mid", o_err_count, 16'h0000);
      strobe(ADDR, 16'd9, 1'b0);
      strobe(ADDR, 16'd10, 1'b0);
      repeat (2) @(negedge clk);
      chk("t6_err", o_err_count, EXP_ERR);
      chk("t6_last", o_data, 16'd10);
      chk("t6_empty", 16'(o_valid), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
